uart_interface: RTL and testbench

Full-duplex 8N1 UART endpoint with a transmitter and a receiver sharing one clock and one reset. The host loads a byte and pulses `transmit`; the block serialises it on `TxD`. In parallel, it deserialises frames arriving on `RxD` and presents each received byte with a one-cycle valid strobe. It sits between the system bus logic and the board-level serial pins.

---
 rtl/uart_interface_if.sv | 26 ++
 rtl/uart_interface.sv | 192 +++++++++++++++++++
 tb/tb_uart_interface.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_interface_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_interface_if : host-side and line-side signal bundle for        |
// |                     uart_interface            Rev 1.0                |
// +----------------------------------------------------------------------+
interface uart_interface_if;
  logic       transmit;
  logic [7:0] TxData;
  logic       tx_busy;
  logic       TxD;
  logic       RxD;
  logic [7:0] RxData;
  logic       rx_valid;
  logic       rx_frame_err;

  modport slave (
    input  transmit, TxData, RxD,
    output tx_busy, TxD, RxData, rx_valid, rx_frame_err
  );

  modport master (
    output transmit, TxData, RxD,
    input  tx_busy, TxD, RxData, rx_valid, rx_frame_err
  );
endinterface
`default_nettype wire

// File: rtl/uart_interface.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_interface : full-duplex 8N1 UART endpoint (TX + RX FSMs).       |
// | Optional macro UART_LOOPBACK_EN feeds TxD back into the receiver.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module uart_interface #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  wire         clk,
  input  wire         reset,
  uart_interface_if.slave bus
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] c_last = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] c_half = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  // Assertion is asynchronous, release is aligned to clk.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  // ---------------- transmitter ----------------
  tx_state_e     tx_state_q;
  logic [CW-1:0] tx_cnt_q;
  logic [2:0]    tx_idx_q;
  logic [7:0]    tx_shift_q;
  logic          txd_q;
  logic          tx_busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (bus.transmit) begin
            tx_shift_q <= bus.TxData;
            txd_q      <= 1'b0;
            tx_busy_q  <= 1'b1;
            tx_cnt_q   <= '0;
            tx_state_q <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt_q == c_last) begin
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            txd_q      <= tx_shift_q[0];
            tx_state_q <= TX_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt_q == c_last) begin
            tx_cnt_q   <= '0;
            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
            if (tx_idx_q == 3'd7) begin
              txd_q      <= 1'b1;
              tx_state_q <= TX_STOP;
            end else begin
              tx_idx_q <= tx_idx_q + 3'd1;
              txd_q    <= tx_shift_q[1];
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt_q == c_last) begin
            tx_cnt_q   <= '0;
            tx_busy_q  <= 1'b0;
            tx_state_q <= TX_IDLE;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  // ---------------- receiver ----------------
  logic rx_line;
`ifdef UART_LOOPBACK_EN
  assign rx_line = txd_q;
`else
  assign rx_line = bus.RxD;
`endif

  logic [1:0] rx_sync_q;
  logic       rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_sync_q <= 2'b11;
    else        rx_sync_q <= {rx_sync_q[0], rx_line};
  end

  assign rx_s = rx_sync_q[1];

  rx_state_e     rx_state_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]    rx_idx_q;
  logic [7:0]    rx_shift_q;
  logic [7:0]    rx_data_q;
  logic          rx_valid_q;
  logic          rx_ferr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (!rx_s) begin
            rx_cnt_q   <= '0;
            rx_state_q <= RX_START;
          end
        end
        RX_START: begin
          // Mid-start-bit check; a high line here was only a glitch.
          if (rx_cnt_q == c_half) begin
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_state_q <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == c_last) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_s, rx_shift_q[7:1]};
            if (rx_idx_q == 3'd7) rx_state_q <= RX_STOP;
            else                  rx_idx_q   <= rx_idx_q + 3'd1;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == c_last) begin
            rx_cnt_q   <= '0;
            rx_state_q <= RX_IDLE;
            if (rx_s) begin
              rx_data_q  <= rx_shift_q;
              rx_valid_q <= 1'b1;
            end else begin
              rx_ferr_q  <= 1'b1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  assign bus.TxD          = txd_q;
  assign bus.tx_busy      = tx_busy_q;
  assign bus.RxData       = rx_data_q;
  assign bus.rx_valid     = rx_valid_q;
  assign bus.rx_frame_err = rx_ferr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_interface.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_interface : directed self-checking bench for uart_interface  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_uart_interface;

  localparam int CPB = 16;

  logic clk;
  logic reset;
  logic lb;
  logic ext_rxd;
  int   cyc;
  int   checks;
  int   errors;

  uart_interface_if u_if ();

  assign u_if.RxD = lb ? u_if.TxD : ext_rxd;

  uart_interface #(
    .CLK_FREQ (1_600_000),
    .BAUD     (100_000)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Receive-side monitor: every strobe is logged with its cycle stamp.
  logic [7:0] rxq[$];
  int         rxt[$];
  int         ferr_cnt;
  int         wide_cnt;
  logic       prev_valid;

  initial begin
    ferr_cnt   = 0;
    wide_cnt   = 0;
    prev_valid = 1'b0;
  end

  always @(posedge clk) begin
    #1;
    if (u_if.rx_valid === 1'b1) begin
      rxq.push_back(u_if.RxData);
      rxt.push_back(cyc);
      if (prev_valid) wide_cnt = wide_cnt + 1;
    end
    if (u_if.rx_frame_err === 1'b1) ferr_cnt = ferr_cnt + 1;
    prev_valid = (u_if.rx_valid === 1'b1);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at #1 after the start-bit edge; samples the middle of all 10 bits.
  task automatic sample_frame(output logic [9:0] bits);
    repeat (CPB / 2) @(posedge clk);
    #1;
    bits[0] = u_if.TxD;
    for (int i = 1; i < 10; i++) begin
      repeat (CPB) @(posedge clk);
      #1;
      bits[i] = u_if.TxD;
    end
  endtask

  task automatic wait_start(output int t);
    t = -1;
    for (int k = 0; k < 4 * CPB; k++) begin
      @(posedge clk);
      #1;
      if (u_if.TxD === 1'b0) begin
        t = cyc;
        break;
      end
    end
    check("start_seen", 32'(t >= 0), 32'd1);
  endtask

  task automatic wait_idle(output int t);
    t = -1;
    for (int k = 0; k < 2 * CPB; k++) begin
      @(posedge clk);
      #1;
      if (u_if.tx_busy === 1'b0) begin
        t = cyc;
        break;
      end
    end
  endtask

  task automatic wait_rx(input int n);
    for (int k = 0; k < 4 * CPB; k++) begin
      if (rxq.size() > n) break;
      @(posedge clk);
      #1;
    end
  endtask

  // Caller is at a negedge; bits[0] goes out first.
  task automatic drive_ext(input logic [9:0] bits);
    for (int i = 0; i < 10; i++) begin
      ext_rxd = bits[i];
      repeat (CPB) @(negedge clk);
    end
    ext_rxd = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;   // {stop, d7..d0, start}
    bit         ext;    // 1: frame arrives on external RxD
  } vec_t;

  logic [7:0] exp_last;

  task automatic run_vec(input vec_t v);
    int n, t0, tend, d;
    logic [9:0] bits;
    n = rxq.size();
    t0 = 0;
    if (!v.ext) begin
      lb = 1'b1;
      @(negedge clk);
      u_if.TxData   = v.data;
      u_if.transmit = 1'b1;
      @(posedge clk);
      #1;
      t0 = cyc;
      u_if.transmit = 1'b0;
      check("req_to_start", {30'd0, u_if.TxD, u_if.tx_busy}, 32'd1);
      sample_frame(bits);
      check("tx_bits", 32'(bits), 32'(v.line));
      wait_idle(tend);
      check("frame_len", 32'(tend - t0), 32'(10 * CPB));
    end else begin
      lb = 1'b0;
      @(negedge clk);
      drive_ext(v.line);
    end
    wait_rx(n);
    check("rx_count", 32'(rxq.size()), 32'(n + 1));
    if (rxq.size() > n) begin
      check("rx_data", 32'(rxq[n]), 32'(v.data));
      if (!v.ext) begin
        d = rxt[n] - t0;
        check("rx_latency_window", 32'(d >= (19 * CPB) / 2 && d <= (19 * CPB) / 2 + 4), 32'd1);
      end
    end
    exp_last = v.data;
  endtask

  vec_t       vecs[4];
  logic [7:0] bb_data[3];
  logic [9:0] bb_line[3];

  initial begin : main
    int n, t0, te, starts, fe0;
    int ts[3];
    logic [9:0] bits;

    checks = 0;
    errors = 0;
    vecs[0] = '{8'hA5, 10'b1101001010, 1'b0};
    vecs[1] = '{8'h81, 10'b1100000010, 1'b0};
    vecs[2] = '{8'h3C, 10'b1001111000, 1'b1};
    vecs[3] = '{8'hE7, 10'b1111001110, 1'b1};
    bb_data[0] = 8'h00; bb_line[0] = 10'b1000000000;
    bb_data[1] = 8'hFF; bb_line[1] = 10'b1111111110;
    bb_data[2] = 8'h3C; bb_line[2] = 10'b1001111000;

    // Reset
    reset = 1'b0;
    u_if.transmit = 1'b0;
    u_if.TxData   = 8'h00;
    ext_rxd  = 1'b1;
    lb       = 1'b0;
    exp_last = 8'h00;
    #100;
    check("rst_txd", 32'(u_if.TxD), 32'd1);
    check("rst_busy", 32'(u_if.tx_busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rel_txd", 32'(u_if.TxD), 32'd1);
    check("rel_busy", 32'(u_if.tx_busy), 32'd0);
    check("rel_rxdata", 32'(u_if.RxData), 32'h00);
    check("rel_strobes", {30'd0, u_if.rx_valid, u_if.rx_frame_err}, 32'd0);
    repeat (4) @(posedge clk);

    // Single frames: loopback through TxD, then external RxD
    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Back-to-back with transmit held high
    lb = 1'b1;
    n  = rxq.size();
    @(negedge clk);
    u_if.TxData   = bb_data[0];
    u_if.transmit = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_start(ts[k]);
      if (k < 2) u_if.TxData = bb_data[k + 1];
      else       u_if.transmit = 1'b0;
      sample_frame(bits);
      check("b2b_bits", 32'(bits), 32'(bb_line[k]));
      wait_idle(te);
      check("b2b_len", 32'(te - ts[k]), 32'(10 * CPB));
      if (k > 0) check("b2b_restart", 32'(ts[k] - ts[k - 1]), 32'(10 * CPB + 1));
    end
    wait_rx(n + 2);
    check("b2b_rx_count", 32'(rxq.size()), 32'(n + 3));
    for (int k = 0; k < 3; k++)
      if (rxq.size() > n + k) check("b2b_rx_data", 32'(rxq[n + k]), 32'(bb_data[k]));
    exp_last = 8'h3C;

    // Second request while busy is dropped
    n = rxq.size();
    @(negedge clk);
    u_if.TxData   = 8'h11;
    u_if.transmit = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    u_if.transmit = 1'b0;
    fork
      sample_frame(bits);
      begin
        repeat (3 * CPB) @(posedge clk);
        #2;
        u_if.TxData   = 8'h22;
        u_if.transmit = 1'b1;
        @(posedge clk);
        #2;
        u_if.transmit = 1'b0;
      end
    join
    check("ignore_bits", 32'(bits), 32'(10'b1000100010));
    wait_idle(te);
    check("ignore_len", 32'(te - t0), 32'(10 * CPB));
    starts = 0;
    for (int k = 0; k < 3 * CPB; k++) begin
      @(posedge clk);
      #1;
      if (u_if.TxD !== 1'b1) starts = starts + 1;
    end
    check("ignore_no_second_frame", 32'(starts), 32'd0);
    check("ignore_rx_count", 32'(rxq.size()), 32'(n + 1));
    if (rxq.size() > n) check("ignore_rx_data", 32'(rxq[n]), 32'h11);
    exp_last = 8'h11;

    // Framing error on external line
    lb  = 1'b0;
    n   = rxq.size();
    fe0 = ferr_cnt;
    @(negedge clk);
    drive_ext(10'b0110000110);
    repeat (2 * CPB) @(negedge clk);
    check("ferr_pulses", 32'(ferr_cnt - fe0), 32'd1);
    check("ferr_no_valid", 32'(rxq.size()), 32'(n));
    check("ferr_rxdata_held", 32'(u_if.RxData), 32'(exp_last));

    // Short low glitch
    fe0 = ferr_cnt;
    ext_rxd = 1'b0;
    repeat (CPB / 2 - 2) @(negedge clk);
    ext_rxd = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("glitch_no_valid", 32'(rxq.size()), 32'(n));
    check("glitch_no_ferr", 32'(ferr_cnt - fe0), 32'd0);

    // Reset in the middle of TX_DATA
    lb = 1'b1;
    n  = rxq.size();
    @(negedge clk);
    u_if.TxData   = 8'h96;
    u_if.transmit = 1'b1;
    @(posedge clk);
    #1;
    u_if.transmit = 1'b0;
    repeat (4 * CPB) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("midrst_txd", 32'(u_if.TxD), 32'd1);
    check("midrst_busy", 32'(u_if.tx_busy), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (12 * CPB) @(posedge clk);
    #1;
    check("midrst_no_valid", 32'(rxq.size()), 32'(n));
    check("midrst_rxdata", 32'(u_if.RxData), 32'h00);
    run_vec('{8'h5A, 10'b1010110100, 1'b0});

    check("rx_valid_single_cycle", 32'(wide_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
